arb4way16: RTL and testbench
============================

# arb4way16

Round-robin arbiter and sequencer for the 4-way 16-bit selector datapath. Four requesters each present a 16-bit word with a request line. The block picks one requester per transfer and drives the selector's 2-bit select from that grant. It registers the chosen word into a single-entry output stage with a valid/ready handshake. It sits between the four producer ports and a single downstream consumer, and is the only block allowed to drive the selector's select input.

## Interface
- `WIDTH`, 16, data word width; all data ports use this width.
- `NREQ`, 4, requester count; fixed at 4. Select width is 2.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req` input 4: `req[i]` high means requester i has a word pending. It must stay high, with its data stable, until `ack[i]`.
- `a`, `b`, `c`, `d` input WIDTH: data from requesters 0, 1, 2, 3.
- `ack` output 4: one-hot, combinational. `ack[i]` is high in the cycle requester i's word is captured.
- `out_valid` output 1: the output register holds an untaken word.
- `out_ready` input 1: the consumer accepts the word when `out_valid && out_ready` at the clock edge.
- `out_data` output WIDTH: the registered word.
- `out_sel` output 2: the registered index of the requester that supplied `out_data`.

## Operation
- **Rotating priority pointer `ptr`** (2 bits).
  - Search order is `ptr`, `ptr+1`, `ptr+2`, `ptr+3`, all mod 4.
  - The first asserted `req` in that order is the grant `gnt`.
- **Capture condition:** `load = |req && (!out_valid || out_ready)`.
- **On `load`:**
  - `out_data` takes the selector output with select `gnt`.
  - `out_sel` takes `gnt`.
  - `out_valid` goes to 1.
  - `ack[gnt]` is 1 in that cycle.
  - `ptr` becomes `gnt+1` mod 4, so 3 wraps to 0.
- **No `load`:** `ptr` holds, and the output register holds unless it is drained.
- **Two-state FSM** on `out_valid`:
  - EMPTY → FULL on `load`.
  - FULL → EMPTY on `out_ready && !load`.
  - FULL → FULL with new contents on `out_ready && load`. This is a back-to-back transfer with no bubble.
  - FULL holds on `!out_ready`: data, `out_sel` and `ptr` are frozen and `ack` is all zero.
- **Fairness:** with all four `req` held high continuously, the grant sequence is 0,1,2,3,0,… Each requester is granted at least once per 4 loads.
- **Words are never dropped or duplicated.** A requester deasserting `req` before its `ack` is a protocol violation; the block simply re-arbitrates.

## Timing
- **Reset values:**
  - `out_valid` = 0, `out_data` = 0, `out_sel` = 0, `ptr` = 0.
  - `ack` is forced to 0 while `rst` is high.
- **Reset mid-transfer:** the pending output word is discarded. No `ack` is issued for any request seen while `rst` is high.
- **Latency:** `req[i]` high in cycle N with the output stage free gives `ack[i]` in cycle N and `out_valid` in cycle N+1.
- **Throughput:** one word per cycle when `out_ready` is held high and any `req` is asserted.
- **`ack` combinational path:** it depends combinationally on `req`, `out_valid`, `out_ready` and `ptr`. There is no combinational path from data to `ack`.
- **`out_*`:** outputs come directly from registers.
- **Simultaneous events:** accept and load in the same cycle replace the word. `out_valid` stays 1 and the new `out_sel` is visible at N+1.
- **Boundaries:**
  - All `req` low while FULL and `out_ready` high: go to EMPTY and `out_data` holds its stale value.
  - A single requester asserting repeatedly is granted every cycle; the pointer only passes over idle requesters.

## Structure
- Shared include file `arb_defs.vh` holds:
  - `SEL_W` = 2.
  - `REQ_A..REQ_D` = 0..3.
  - The FSM state encodings `ST_EMPTY` = 0 and `ST_FULL` = 1.
- Instantiate the existing `mux4way16` once as the data selector, with `sel` driven by `gnt`. Do not duplicate the mux logic.
- Grant search, pointer and FSM live in `arb4way16` itself. No further sub-modules.

## Test plan
- **Reset:** assert `rst` mid-stream with `req`=4'b1111 → `out_valid`=0, `out_data`=0, `out_sel`=0, `ack`=0. The first grant after release is requester 0.
- **Rotation:** `a..d`=16'h0001/0002/0004/0008, `req`=4'b1111, `out_ready`=1 held → `out_sel` sequence 0,1,2,3,0 with matching `out_data`, one per cycle, no bubbles.
- **Pointer skip:** `req`=4'b1010 held, `out_ready`=1 → grants alternate 1,3,1,3. Wrap from 3 goes back to 1.
- **Backpressure:** `out_ready`=0 for 5 cycles while FULL with `req`=4'b0100 → `out_data`, `out_sel` and `ptr` are frozen and `ack`=0. When `out_ready` rises, that cycle shows `ack[2]`=1 and a back-to-back replace.
- **Drain:** single word from requester 3 (16'hBEEF), then `req`=0 and `out_ready`=1 → `out_valid` goes 1 then 0, with `out_data`=16'hBEEF, `out_sel`=3.
- **Fairness soak:** random `req` held until `ack`, random `out_ready`, 10k cycles → scoreboard shows no lost or duplicated words, and every held request is acked within 4 loads.

Source files
------------

// File: rtl/arb4way16_pkg.sv
// arb4way16_pkg: shared widths, requester indices, FSM states and round-robin pick
package arb4way16_pkg;
    localparam int WIDTH = 16;
    localparam int NREQ = 4;
    localparam int SEL_W = 2;
    localparam logic [SEL_W-1:0] REQ_A = 2'd0;
    localparam logic [SEL_W-1:0] REQ_B = 2'd1;
    localparam logic [SEL_W-1:0] REQ_C = 2'd2;
    localparam logic [SEL_W-1:0] REQ_D = 2'd3;
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;
    // Scanning from the far end lets the nearest asserted requester (from ptr) overwrite the result last.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [NREQ-1:0] req, input logic [SEL_W-1:0] ptr);
        rr_pick = ptr;
        for (int k = NREQ - 1; k >= 0; k--)
            if (req[ptr + SEL_W'(k)]) rr_pick = ptr + SEL_W'(k);
    endfunction
endpackage

// File: rtl/arb4way16_if.sv
// arb4way16_if: requester-side and consumer-side signals of the arbiter
interface arb4way16_if;
    import arb4way16_pkg::*;
    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  ack;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [SEL_W-1:0] out_sel;
    modport master (input req, a, b, c, d, out_ready, output ack, out_valid, out_data, out_sel);
    modport slave (output req, a, b, c, d, out_ready, input ack, out_valid, out_data, out_sel);
endinterface

// File: rtl/mux4way16.sv
// mux4way16: 4-way 16-bit word selector
module mux4way16 import arb4way16_pkg::*; (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] out
);
    // pure select; every sel value is covered
    always_comb begin
        out = a;
        unique case (sel)
            REQ_A: out = a;
            REQ_B: out = b;
            REQ_C: out = c;
            REQ_D: out = d;
        endcase
    end
endmodule

// File: rtl/arb4way16.sv
// arb4way16: round-robin arbiter feeding a single-entry valid/ready output stage
module arb4way16 import arb4way16_pkg::*; (
    input  logic        clk,
    input  logic        rst,
    arb4way16_if.master bus
);
    state_t           state;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] gnt;
    logic [SEL_W-1:0] sel_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] mux_out;
    logic             load;

    mux4way16 u_mux (
        .a   (bus.a),
        .b   (bus.b),
        .c   (bus.c),
        .d   (bus.d),
        .sel (gnt),
        .out (mux_out)
    );

    // grant search and capture decision; data never feeds ack
    always_comb begin
        gnt  = rr_pick(bus.req, ptr);
        load = |bus.req && (state == ST_EMPTY || bus.out_ready);
    end

    assign bus.ack       = (load && !rst) ? NREQ'(1) << gnt : '0;
    assign bus.out_valid = state == ST_FULL;
    assign bus.out_data  = data_q;
    assign bus.out_sel   = sel_q;

    // output stage FSM: a load always (re)fills, an accept without load empties
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_EMPTY;
            data_q <= '0;
            sel_q  <= '0;
            ptr    <= '0;
        end else if (load) begin
            state  <= ST_FULL;
            data_q <= mux_out;
            sel_q  <= gnt;
            ptr    <= gnt + 1'b1;
        end else if (state == ST_FULL && bus.out_ready) begin
            state  <= ST_EMPTY;
        end
    end
endmodule

// File: tb/tb_arb4way16.sv
// tb_arb4way16: scoreboard bench for the round-robin arbiter
module tb_arb4way16;
    import arb4way16_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    arb4way16_if bus();

    arb4way16 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [1:0]  mptr = 2'd0;
    logic        mvalid = 1'b0;
    logic [17:0] sbq[$];
    int          waits[4];
    logic [3:0]  last_ack = 4'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] word(input int i);
        return i == 0 ? bus.a : i == 1 ? bus.b : i == 2 ? bus.c : bus.d;
    endfunction

    task automatic set_word(input int i, input logic [15:0] v);
        if (i == 0) bus.a = v;
        else if (i == 1) bus.b = v;
        else if (i == 2) bus.c = v;
        else bus.d = v;
    endtask

    task automatic model_reset();
        mptr = 2'd0;
        mvalid = 1'b0;
        sbq.delete();
        for (int i = 0; i < 4; i++) waits[i] = 0;
        last_ack = 4'd0;
    endtask

    // one clock: inputs already driven; sample mid-cycle, update model, advance to edge+1
    task automatic step();
        int g;
        logic found;
        logic ld;
        logic [17:0] e;
        @(negedge clk);
        found = 1'b0;
        g = 0;
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (int'(mptr) + k) % 4;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                g = idx;
            end
        end
        ld = found && (!mvalid || bus.out_ready);
        check("ack", bus.ack, ld ? (32'd1 << g) : 32'd0);
        check("out_valid", bus.out_valid, mvalid);
        if (mvalid) begin
            if (sbq.size() == 0) check("sb_size", sbq.size(), 1);
            else begin
                e = sbq[0];
                check("out_sel", bus.out_sel, e[17:16]);
                check("out_data", bus.out_data, e[15:0]);
                if (bus.out_ready) void'(sbq.pop_front());
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (bus.req[i] && ld) begin
                waits[i]++;
                if (g == i) begin
                    check("fair_wait", waits[i] <= 4, 1);
                    waits[i] = 0;
                end
            end else if (!bus.req[i]) waits[i] = 0;
        end
        if (ld) begin
            sbq.push_back({2'(g), word(g)});
            mptr = 2'(g + 1);
        end
        mvalid = ld ? 1'b1 : (mvalid && bus.out_ready) ? 1'b0 : mvalid;
        last_ack = bus.ack;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] r;
        bus.req = 4'd0;
        bus.a = '0;
        bus.b = '0;
        bus.c = '0;
        bus.d = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.req = 4'b1111;
        #1;
        check("rst_ack", bus.ack, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_data", bus.out_data, 0);
        check("rst_sel", bus.out_sel, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        bus.a = 16'h0001;
        bus.b = 16'h0002;
        bus.c = 16'h0004;
        bus.d = 16'h0008;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("rot_sel", bus.out_sel, i % 4);
            check("rot_data", bus.out_data, 32'd1 << (i % 4));
            check("rot_valid", bus.out_valid, 1);
        end

        rst = 1'b1;
        #1;
        check("midrst_ack", bus.ack, 0);
        check("midrst_valid", bus.out_valid, 0);
        check("midrst_data", bus.out_data, 0);
        check("midrst_sel", bus.out_sel, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        step();
        check("first_after_rst", bus.out_sel, 0);

        bus.req = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            step();
            check("skip_sel", bus.out_sel, (i % 2) ? 3 : 1);
        end

        bus.req = 4'b0100;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_ack", last_ack, 0);
            check("bp_sel", bus.out_sel, 3);
            check("bp_data", bus.out_data, 16'h0008);
        end
        bus.out_ready = 1'b1;
        step();
        check("bp_release_ack", last_ack, 4'b0100);
        check("bp_release_sel", bus.out_sel, 2);
        check("bp_release_data", bus.out_data, 16'h0004);

        bus.req = 4'b0000;
        step();
        bus.d = 16'hBEEF;
        bus.req = 4'b1000;
        step();
        check("drain_valid1", bus.out_valid, 1);
        check("drain_sel1", bus.out_sel, 3);
        check("drain_data1", bus.out_data, 16'hBEEF);
        bus.req = 4'b0000;
        step();
        check("drain_valid0", bus.out_valid, 0);
        check("drain_stale_sel", bus.out_sel, 3);
        check("drain_stale_data", bus.out_data, 16'hBEEF);

        for (int n = 0; n < 10000; n++) begin
            r = bus.req;
            for (int i = 0; i < 4; i++) begin
                if (!(r[i] && !last_ack[i])) begin
                    r[i] = 1'($urandom_range(0, 1));
                    if (r[i]) set_word(i, 16'($urandom));
                end
            end
            bus.req = r;
            bus.out_ready = $urandom_range(0, 3) != 0;
            step();
        end
        bus.req = 4'd0;
        bus.out_ready = 1'b1;
        step();
        step();
        check("soak_empty_sb", sbq.size(), 0);
        check("soak_valid", bus.out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
